// File: rtl/ad5676_spi_tx_if.sv
// Sample handshake bundle between the wave sender and ad5676_spi_tx.
// Fields: wr_valid, wr_ready, wr_data[7:0], wr_ch[2:0].
interface ad5676_spi_tx_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [2:0] wr_ch;

  modport master (
    output wr_valid, wr_data, wr_ch,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_data, wr_ch,
    output wr_ready
  );
endinterface

// File: rtl/ad5676_spi_tx.sv
// AD5676 SPI serializer: one 24-bit write+update frame per sample handshake.
// Ports: clk, rst_n (async low), wr (slave handshake), frame_done, spi_sync_n/sclk/sdin.
// Macro AD5676_SOFT_RESET_EN: send a software-reset frame (0x701234) after reset.
module ad5676_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_GAP = 2,
  parameter logic [3:0]  CMD      = 4'b0011
) (
  input  logic           clk,
  input  logic           rst_n,
  ad5676_spi_tx_if.slave wr,
  output logic           frame_done,
  output logic           spi_sync_n,
  output logic           spi_sclk,
  output logic           spi_sdin
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(SYNC_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, TAIL, GAP, INIT
  } state_t;

`ifdef AD5676_SOFT_RESET_EN
  localparam state_t RST_ST = INIT;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          half_q, half_d;
  logic [4:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   frame_q, frame_d;
  logic          sclk_d, sdin_d, sync_d, done_d;

  logic          load;
  logic [23:0]   load_frame;
  logic          div_last;

  assign wr.wr_ready = (state_q == IDLE);
  assign div_last    = (div_q == DIV_MAX);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    sclk_d     = spi_sclk;
    sdin_d     = spi_sdin;
    sync_d     = spi_sync_n;
    done_d     = 1'b0;
    load       = 1'b0;
    load_frame = {CMD, 1'b0, wr.wr_ch,
                  wr.wr_data, wr.wr_data};

    unique case (state_q)
      IDLE: load = wr.wr_valid;
`ifdef AD5676_SOFT_RESET_EN
      INIT: begin
        load       = 1'b1;
        load_frame = 24'h701234;
      end
`endif
      SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b0;
          end else begin
            half_d = 1'b0;
            sclk_d = 1'b1;
            if (bit_q == 5'd0) begin
              state_d = TAIL;
              sdin_d  = 1'b0;
            end else begin
              bit_d  = bit_q - 5'd1;
              sdin_d = frame_q[bit_q - 5'd1];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      TAIL: begin
        if (div_last) begin
          div_d   = '0;
          state_d = GAP;
          sync_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_MAX) begin
          gap_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: SYNC falls with the MSB already on SDIN and SCLK high.
    if (load) begin
      state_d = SHIFT;
      frame_d = load_frame;
      bit_d   = 5'd23;
      div_d   = '0;
      half_d  = 1'b0;
      sclk_d  = 1'b1;
      sdin_d  = load_frame[23];
      sync_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_ST;
      div_q      <= '0;
      half_q     <= 1'b0;
      bit_q      <= 5'd0;
      gap_q      <= '0;
      frame_q    <= '0;
      spi_sclk   <= 1'b1;
      spi_sdin   <= 1'b0;
      spi_sync_n <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      spi_sclk   <= sclk_d;
      spi_sdin   <= sdin_d;
      spi_sync_n <= sync_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_ad5676_spi_tx.sv
// Directed bench for ad5676_spi_tx: default and CLK_DIV=1/SYNC_GAP=1 instances.
// Expected frames and cycle numbers are hand-derived from the frame timing.
module tb_ad5676_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ad5676_spi_tx_if bus ();
  ad5676_spi_tx_if fbus ();

  logic done, sync_n, sclk, sdin;
  logic f_done, f_sync, f_sclk, f_sdin;

  ad5676_spi_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (bus),
    .frame_done (done),
    .spi_sync_n (sync_n),
    .spi_sclk   (sclk),
    .spi_sdin   (sdin)
  );

  ad5676_spi_tx #(
    .CLK_DIV  (1),
    .SYNC_GAP (1)
  ) dut_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (fbus),
    .frame_done (f_done),
    .spi_sync_n (f_sync),
    .spi_sclk   (f_sclk),
    .spi_sdin   (f_sdin)
  );

`ifdef AD5676_SOFT_RESET_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  int total = 0;
  int bad = 0;

  logic [23:0] bits;
  int nfall, nlow, nwin, ngap, rdy, done_at;
  bit ok;

  // Monitors one frame cycle by cycle, starting at cycle 1 after a handshake.
  // Returns at the negedge of the first cycle with wr_ready high.
  task automatic capture(input bit fast, input bit scramble, input int budget);
    logic ps, pc, s, c, d, fd, r;
    bits = '0; nfall = 0; nlow = 0; nwin = 0;
    ngap = 0; rdy = -1; done_at = -1;
    ps = 1'b1; pc = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      s  = fast ? f_sync : sync_n;
      c  = fast ? f_sclk : sclk;
      d  = fast ? f_sdin : sdin;
      fd = fast ? f_done : done;
      r  = fast ? fbus.wr_ready : bus.wr_ready;
      if (!s) nlow++;
      if (ps && !s) nwin++;
      if (s && nlow > 0 && !r) ngap++;
      if (pc && !c) begin
        nfall++;
        if (!s) bits = {bits[22:0], d};
      end
      if (fd) done_at = cyc;
      if (scramble) begin
        bus.wr_data = 8'($urandom);
        bus.wr_ch   = 3'($urandom);
      end
      if (r) begin
        rdy = cyc;
        break;
      end
      ps = s; pc = c;
      @(posedge clk);
    end
  endtask

  // Offers a sample and returns #1 after the handshake edge.
  task automatic offer(input bit fast, input logic [2:0] ch,
                       input logic [7:0] data, input bit hold);
    logic r;
    if (fast) begin
      fbus.wr_valid = 1'b1; fbus.wr_ch = ch; fbus.wr_data = data;
    end else begin
      bus.wr_valid = 1'b1; bus.wr_ch = ch; bus.wr_data = data;
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = fast ? fbus.wr_ready : bus.wr_ready;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.wr_valid = 1'b0;
      fbus.wr_valid = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL offer_ready: got 0 want 1 (ch=%0d)", ch);
    end
  endtask

  task automatic after_reset();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef AD5676_SOFT_RESET_EN
    @(posedge clk);
    #1;
    capture(1'b0, 1'b0, 200);
    total++;
    if (bits !== 24'h701234) begin
      bad++; $display("FAIL init_frame: got %h want 701234", bits);
    end
    total++;
    if (nlow != 98) begin
      bad++; $display("FAIL init_low: got %0d want 98", nlow);
    end
    total++;
    if (rdy != 101 || done_at != 101) begin
      bad++;
      $display("FAIL init_ready: got rdy=%0d done=%0d want 101", rdy, done_at);
    end
`else
    @(negedge clk);
    total++;
    if (bus.wr_ready !== 1'b1 || sync_n !== 1'b1) begin
      bad++;
      $display("FAIL first_idle: got rdy=%b sync=%b want 1 1", bus.wr_ready, sync_n);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sync_n !== 1'b1) begin
      bad++; $display("FAIL rst_sync: got %b want 1", sync_n);
    end
    total++;
    if (sclk !== 1'b1) begin
      bad++; $display("FAIL rst_sclk: got %b want 1", sclk);
    end
    total++;
    if (sdin !== 1'b0) begin
      bad++; $display("FAIL rst_sdin: got %b want 0", sdin);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %b want 0", done);
    end
    total++;
    if (bus.wr_ready !== RST_READY) begin
      bad++; $display("FAIL rst_ready: got %b want %b", bus.wr_ready, RST_READY);
    end
    after_reset();
  endtask

  task automatic test_single();
    offer(1'b0, 3'd3, 8'hA5, 1'b0);
    capture(1'b0, 1'b0, 200);
    total++;
    if (bits !== 24'h33A5A5) begin
      bad++; $display("FAIL single_bits: got %h want 33a5a5", bits);
    end
    total++;
    if (nfall != 24) begin
      bad++; $display("FAIL single_falls: got %0d want 24", nfall);
    end
    total++;
    if (nlow != 98 || nwin != 1) begin
      bad++; $display("FAIL single_low: got %0d/%0d want 98/1", nlow, nwin);
    end
    total++;
    if (rdy != 101) begin
      bad++; $display("FAIL single_ready: got %0d want 101", rdy);
    end
    total++;
    if (done_at != 101) begin
      bad++; $display("FAIL single_done: got %0d want 101", done_at);
    end
  endtask

  task automatic test_back_to_back();
    offer(1'b0, 3'd0, 8'h00, 1'b1);
    capture(1'b0, 1'b0, 200);
    total++;
    if (bits !== 24'h300000) begin
      bad++; $display("FAIL b2b_first: got %h want 300000", bits);
    end
    total++;
    if (ngap != 2) begin
      bad++; $display("FAIL b2b_gap: got %0d want 2", ngap);
    end
    total++;
    if (rdy != 101) begin
      bad++; $display("FAIL b2b_handshake: got %0d want 101", rdy);
    end
    bus.wr_ch = 3'd7;
    bus.wr_data = 8'hFF;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    capture(1'b0, 1'b0, 200);
    total++;
    if (bits !== 24'h37FFFF || nwin != 1) begin
      bad++; $display("FAIL b2b_second: got %h/%0d want 37ffff/1", bits, nwin);
    end
    total++;
    if (rdy != 101) begin
      bad++; $display("FAIL b2b_second_ready: got %0d want 101", rdy);
    end
  endtask

  task automatic test_input_hold();
    offer(1'b0, 3'd6, 8'h5A, 1'b0);
    capture(1'b0, 1'b1, 200);
    total++;
    if (bits !== 24'h365A5A) begin
      bad++; $display("FAIL hold_bits: got %h want 365a5a", bits);
    end
    total++;
    if (rdy != 101) begin
      bad++; $display("FAIL hold_ready: got %0d want 101", rdy);
    end
  endtask

  task automatic test_reset_abort();
    int nf;
    int seen;
    logic pc;
    offer(1'b0, 3'd5, 8'h3C, 1'b0);
    nf = 0;
    pc = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pc && !sclk) nf++;
      pc = sclk;
      if (nf == 10) break;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (nf != 10) begin
      bad++; $display("FAIL abort_falls: got %0d want 10", nf);
    end
    total++;
    if (sync_n !== 1'b1 || sclk !== 1'b1 || sdin !== 1'b0) begin
      bad++;
      $display("FAIL abort_pins: got %b%b%b want 110", sync_n, sclk, sdin);
    end
    total++;
    if (bus.wr_ready !== RST_READY) begin
      bad++; $display("FAIL abort_ready: got %b want %b", bus.wr_ready, RST_READY);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_done: got %0d pulses want 0", seen);
    end
    after_reset();
    offer(1'b0, 3'd5, 8'h3C, 1'b0);
    capture(1'b0, 1'b0, 200);
    total++;
    if (bits !== 24'h353C3C || nfall != 24) begin
      bad++; $display("FAIL abort_next: got %h/%0d want 353c3c/24", bits, nfall);
    end
    total++;
    if (done_at != 101) begin
      bad++; $display("FAIL abort_next_done: got %0d want 101", done_at);
    end
  endtask

  task automatic test_fast_params();
    offer(1'b1, 3'd2, 8'h81, 1'b0);
    capture(1'b1, 1'b0, 120);
    total++;
    if (bits !== 24'h328181 || nfall != 24) begin
      bad++; $display("FAIL fast_bits: got %h/%0d want 328181/24", bits, nfall);
    end
    total++;
    if (nlow != 49) begin
      bad++; $display("FAIL fast_low: got %0d want 49", nlow);
    end
    total++;
    if (rdy != 51 || done_at != 51) begin
      bad++; $display("FAIL fast_ready: got %0d/%0d want 51", rdy, done_at);
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'h00;
    bus.wr_ch = 3'd0;
    fbus.wr_valid = 1'b0;
    fbus.wr_data = 8'h00;
    fbus.wr_ch = 3'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_input_hold();
    test_reset_abort();
    test_fast_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad5676_spi_tx.md
# ad5676_spi_tx

Serializer stage directly downstream of the waveform sender. It accepts one 8-bit DAC sample plus a channel index per valid/ready handshake. It expands the sample to 16 bits and builds the 24-bit AD5676 "write and update channel n" frame. It shifts the frame out on the AD5676 SPI pins: SYNC_n, SCLK and SDIN.

## Interface

Parameters:
- `CLK_DIV`, default 2 — SCLK half-period in `clk` cycles; legal range ≥1.
- `SYNC_GAP`, default 2 — minimum `spi_sync_n` high time between frames, in `clk` cycles; legal range ≥1.
- `CMD`, default 4'b0011 — command nibble for sample frames (write and update DAC channel n).

Ports:
- `clk` input 1 — system clock; all logic on its rising edge.
- `rst_n` input 1 — asynchronous active-low reset.
- `wr_valid` input 1 — sample offered.
- `wr_ready` output 1 — block idle and able to accept.
- `wr_data` input 8 — sample from the wave sender.
- `wr_ch` input 3 — DAC channel, 0–7.
- `frame_done` output 1 — one-cycle pulse when a frame and its gap have completed.
- `spi_sync_n` output 1 — AD5676 SYNC, active low.
- `spi_sclk` output 1 — AD5676 SCLK.
- `spi_sdin` output 1 — AD5676 SDIN, MSB first.

## Operation

- **States:** IDLE → SHIFT → TAIL → GAP → IDLE. With the macro enabled, INIT precedes IDLE (see Configuration).
- **Handshake:**
  - `wr_ready` = (state == IDLE).
  - A transfer occurs on the cycle where `wr_valid && wr_ready`.
  - `wr_data` and `wr_ch` are registered only on that cycle; later changes have no effect on the frame.
  - `wr_valid` while not ready is ignored; the source must hold it.
- **Frame format:** 24 bits = {`CMD`[3:0], 1'b0, `wr_ch`[2:0], `wr_data`, `wr_data`}.
  - Sample expansion is a byte repeat, so 0x00 → 0x0000 and 0xFF → 0xFFFF (full scale).
- **SHIFT:** 24 bit periods of 2·`CLK_DIV` cycles each.
  - First half of each period: `spi_sclk`=1, with `spi_sdin` = the current bit.
  - Second half: `spi_sclk`=0, so the DAC samples on the falling edge at mid-period.
  - `spi_sdin` changes only when `spi_sclk` rises, or on SHIFT entry.
- **TAIL:** `spi_sclk`=1 and `spi_sync_n`=0 for `CLK_DIV` cycles.
- **GAP:** `spi_sync_n`=1 for `SYNC_GAP` cycles.
  - `frame_done` pulses on the first IDLE cycle after GAP.
- **Idle levels:** `spi_sync_n`=1, `spi_sclk`=1, `spi_sdin`=0.
- **Reset:** asserting `rst_n` at any point, including mid-frame, drives idle levels immediately and aborts the frame.
  - SYNC_n rising before the 24th falling edge causes the AD5676 to discard the frame; this is the required abort behaviour.
  - Reset values: `spi_sync_n`=1, `spi_sclk`=1, `spi_sdin`=0, `frame_done`=0.
  - `wr_ready`=1 without the macro and 0 with it.
- **Counters:**
  - Half-period divider counts 0..`CLK_DIV`-1.
  - Bit counter counts 23..0.
  - Gap counter counts 0..`SYNC_GAP`-1.
  - No counter wraps outside its state.

## Timing

- Handshake cycle = cycle 0.
- `spi_sync_n` is low, with MSB on `spi_sdin`, during cycles 1 … 49·`CLK_DIV`.
  - 48·`CLK_DIV` cycles of SHIFT, then `CLK_DIV` cycles of TAIL.
- GAP occupies cycles 49·`CLK_DIV`+1 … 49·`CLK_DIV`+`SYNC_GAP`.
- `wr_ready` and `frame_done` are high at cycle 49·`CLK_DIV`+`SYNC_GAP`+1.
  - With defaults this is cycle 101.
- Back-to-back throughput: one frame per 49·`CLK_DIV`+`SYNC_GAP`+1 cycles.
- All outputs are registered; there is no combinational path from inputs to SPI pins.
- `wr_ready` is a decode of the state register.

## Configuration

- Macro: `AD5676_SOFT_RESET_EN`.
- **Defined:**
  - After `rst_n` deasserts, the block enters INIT instead of IDLE.
  - INIT sends one software-reset frame, 0x701234 (command 0111, address 0000, data 0x1234), with identical SPI timing.
  - `wr_ready` stays 0 until that frame's GAP completes.
  - `frame_done` pulses once for it.
- **Undefined:** INIT is not built, and the block enters IDLE with `wr_ready`=1 on the first cycle after reset.

## Test plan

- `wr_ch`=3, `wr_data`=0xA5, defaults → exactly one SYNC_n low window of 98 cycles, exactly 24 SCLK falling edges, and bits sampled at the falling edges = 0x33A5A5 MSB first.
- `wr_ch`=0, `wr_data`=0x00, then `wr_ch`=7, `wr_data`=0xFF with `wr_valid` held → frames 0x300000 and 0x37FFFF; second handshake at cycle 101; `spi_sync_n` high for exactly 2 cycles between the frames.
- Change `wr_data` and `wr_ch` every cycle during a frame → the transmitted frame matches the values at the handshake cycle only; `wr_ready` stays 0 until cycle 101.
- Assert `rst_n`=0 after the 10th falling edge → `spi_sync_n`=1 and `spi_sclk`=1 within the same cycle; no `frame_done`; the next frame after release is complete and correct.
- `CLK_DIV`=1, `SYNC_GAP`=1 → SYNC_n low for 49 cycles; `wr_ready` back at cycle 51.
- `AD5676_SOFT_RESET_EN` defined → first frame after reset is 0x701234; `wr_ready`=0 until cycle 101 after SYNC_n first falls, counted like a handshake at cycle 0.
